// File: rtl/aes_pkg.sv
// Shared AES definitions: datapath widths, arbiter FSM state type and the
// forward S-box table used by the substitution lane.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/sbox_word.sv
// One 32-bit substitution lane: four independent combinational S-box lookups.
module sbox_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word_in,
    output logic [WORD_W-1:0] word_out
);

    genvar gi;
    generate
        for (gi = 0; gi < WORD_W / 8; gi++) begin : g_byte
            assign word_out[8*gi +: 8] = sbox_lookup(word_in[8*gi +: 8]);
        end
    endgenerate

endmodule

// File: rtl/sbox_arbiter.sv
// Shares one S-box lane between a column-serial SubBytes state path and a
// single-cycle key-schedule SubWord path; ks requests win except back-to-back in BUSY.
module sbox_arbiter
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               st_valid,
    input  logic [STATE_W-1:0] st_data,
    output logic               st_ready,
    output logic               st_out_valid,
    output logic [STATE_W-1:0] st_out_data,
    input  logic               st_out_ready,
    input  logic               ks_valid,
    input  logic [WORD_W-1:0]  ks_word,
    output logic               ks_ready,
    output logic               ks_out_valid,
    output logic [WORD_W-1:0]  ks_out_word
);

    arb_state_t         state_reg;
    logic [1:0]         beat_reg;
    logic               alt_reg;
    logic [STATE_W-1:0] in_buf_reg;
    logic [STATE_W-1:0] out_buf_reg;
    logic               ks_out_valid_reg;
    logic [WORD_W-1:0]  ks_out_word_reg;

    logic               ks_grant;
    logic [6:0]         col_lsb;
    logic [WORD_W-1:0]  lane_in;
    logic [WORD_W-1:0]  lane_out;

    assign st_ready     = (state_reg == IDLE);
    // A ks grant in BUSY blocks the next ks request so the state beat gets the lane.
    assign ks_ready     = !((state_reg == BUSY) && alt_reg);
    assign ks_grant     = ks_valid && ks_ready;
    assign st_out_valid = (state_reg == DONE);
    assign st_out_data  = out_buf_reg;
    assign ks_out_valid = ks_out_valid_reg;
    assign ks_out_word  = ks_out_word_reg;

    // Beat 0 is the most significant column, so the LSB is (3 - beat) * 32.
    assign col_lsb = {~beat_reg, 5'd0};
    assign lane_in = ks_grant ? ks_word : in_buf_reg[col_lsb +: WORD_W];

    sbox_word u_lane (
        .word_in  (lane_in),
        .word_out (lane_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            beat_reg         <= 2'd0;
            alt_reg          <= 1'b0;
            in_buf_reg       <= '0;
            out_buf_reg      <= '0;
            ks_out_valid_reg <= 1'b0;
            ks_out_word_reg  <= '0;
        end else begin
            ks_out_valid_reg <= ks_grant;
            if (ks_grant) begin
                ks_out_word_reg <= lane_out;
            end
            alt_reg <= (state_reg == BUSY) && ks_grant;

            case (state_reg)
                IDLE: begin
                    if (st_valid) begin
                        in_buf_reg <= st_data;
                        beat_reg   <= 2'd0;
                        state_reg  <= BUSY;
                    end
                end
                BUSY: begin
                    if (!ks_grant) begin
                        out_buf_reg[col_lsb +: WORD_W] <= lane_out;
                        beat_reg <= beat_reg + 2'd1;
                        if (beat_reg == 2'd3) begin
                            state_reg <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (st_out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sbox_arbiter.md
SBOX_ARBITER -- requirements
Module: sbox_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: st_valid  in  1  state request valid; st_data  in  128  AES state to substitute; st_ready  out  1  state request accepted.
REQ-003 SHALL have ports: st_out_valid  out  1  result valid; st_out_data  out  128  SubBytes(st_data); st_out_ready  in  1  consumer accepts result.
REQ-004 SHALL have ports: ks_valid  in  1  key-schedule SubWord request; ks_word  in  32  word to substitute; ks_ready  out  1  ks request granted this cycle.
REQ-005 SHALL have ports: ks_out_valid  out  1  one-cycle result pulse, no back-pressure; ks_out_word  out  32  SubWord(ks_word).
REQ-006 SHALL have no parameters; all widths are fixed (128-bit state, 32-bit lane).

Function
REQ-007 SHALL share one 32-bit S-box lane (4 byte lookups) between the state path and the key-schedule path; at most one operand uses the lane per cycle.
REQ-008 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-009 SHALL drive st_ready=1 only in IDLE; st_valid&&st_ready loads st_data into an input buffer, clears beat counter to 0, and moves to BUSY.
REQ-010 SHALL, in BUSY, process one column per lane cycle: beat b substitutes bits [127-32b:96-32b] and writes the result into the same bit range of the output buffer; beat order 0,1,2,3.
REQ-011 SHALL move BUSY->DONE on the edge that registers beat 3; DONE holds st_out_valid=1 and st_out_data stable until st_out_ready=1, then returns to IDLE on that edge.
REQ-012 SHALL give minimum state latency of 5 cycles: accepted at edge of cycle T, st_out_valid high from cycle T+5 when no ks grants intervene.
REQ-013 SHALL drive ks_ready=1 in every cycle except a BUSY cycle immediately following a BUSY-cycle ks grant (alternation guarantees state progress).
REQ-014 SHALL, on ks_valid&&ks_ready, use the lane for ks_word that cycle; a BUSY beat scheduled in that cycle stalls (counter unchanged).
REQ-015 SHALL register ks_out_word and pulse ks_out_valid for exactly one cycle, the cycle after the grant.
REQ-016 SHALL accept a state request and a ks request in the same IDLE cycle (loading the state buffer does not use the lane).
REQ-017 SHALL keep st_ready=0 in DONE; no state acceptance on the cycle DONE->IDLE.
REQ-018 SHALL, under continuous ks_valid during BUSY, complete the state in at most 8 lane cycles (alternating ks/beat).
REQ-019 SHALL ignore st_out_ready outside DONE and ks_word/st_data when the corresponding request is not granted.

Reset
REQ-020 SHALL on rst_n=0 immediately (asynchronously) enter IDLE and clear beat counter, alternation flag, and both buffers.
REQ-021 SHALL reset outputs: st_ready=1 once rst_n is released (IDLE), st_out_valid=0, st_out_data=0, ks_ready=1, ks_out_valid=0, ks_out_word=0.
REQ-022 SHALL discard any in-flight state or ks operation on reset without producing a result.

Structure
REQ-023 SHALL place in shared package aes_pkg: state width 128, word width 32, FSM state type, the 256-entry S-box constant table.
REQ-024 SHALL instantiate exactly one sub-module sbox_word (32-bit in, 32-bit out, four combinational S-box lookups) as the shared lane.

Verification
REQ-025 SHALL cover: st_data=00102030405060708090a0b0c0d0e0f0, no ks -> st_out_data=63cab7040953d051cd60e0e7ba70e18c, st_out_valid at T+5.
REQ-026 SHALL cover: ks_word=cf4f3c09 in IDLE -> ks_out_word=8a84eb01, ks_out_valid one cycle after grant, single-cycle pulse.
REQ-027 SHALL cover: st_data=89d810e8855ace682d1843d8cb128fe4 with ks_valid held high throughout BUSY -> a761ca9b97be8b45d8ad1a611fc97369, ks_ready alternating 1/0 in BUSY, state done within 8 lane cycles.
REQ-028 SHALL cover: simultaneous st_valid and ks_valid in IDLE -> both accepted same cycle; ks result next cycle; state result correct.
REQ-029 SHALL cover: result 1f770c64f0b579deaaac432c3d37cf0e (input cb02818c17d2af9c62aa64428bb25fd7) with st_out_ready low 3 cycles -> output held stable, st_ready=0, IDLE after handshake.
REQ-030 SHALL cover: rst_n asserted during beat 2 -> all outputs at reset values immediately, no st_out_valid after release.
